bcd_entry_sequencer: RTL and testbench
======================================

Name: bcd_entry_sequencer

Overview:
Front-end sequencer for the 2-digit BCD calculator datapath; sits directly upstream of the BCD ALU.
- Accepts one-cycle keypad strobes and assembles BCD operands digit by digit.
- Drives the ALU op1/op2/opcode inputs and, on "=", waits a fixed latency, then captures the ALU result and carry.
- Presents the active operand or captured result to the display stage.

Parameters:
WIDTH, 8, operand width in bits; multiple of 4; digit count D = WIDTH/4
LATCH_DELAY, 1, cycles from "=" acceptance to result capture; legal range >= 1

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
key_strobe  input  1  one-cycle pulse, key_code valid
key_code  input  4  0x0-0x9 digit, 0xA add, 0xB subtract, 0xC equals, 0xD clear, 0xE/0xF ignored
alu_result  input  WIDTH  BCD result from ALU
alu_c_out  input  1  ALU MSD carry out
op1  output  WIDTH  ALU operand 1 (BCD)
op2  output  WIDTH  ALU operand 2 (BCD)
opcode  output  2  00 idle, 01 add, 10 subtract
disp_value  output  WIDTH  value shown on display
disp_carry  output  1  captured carry, shown only in SHOW
result_valid  output  1  one-cycle pulse after result capture
busy  output  1  high in WAIT

Behaviour:
- Reset (nrst low, asynchronous):
  - op1, op2, result register, carry register and delay counter all 0.
  - opcode 00, result_valid 0, state ENTER_OP1.
- Registered outputs: a key sampled at edge N is reflected after edge N.
- States: ENTER_OP1, ENTER_OP2, WAIT, SHOW.
- Digit entry: operand <= {operand[WIDTH-5:0], key_code}.
  - The most-significant digit is shifted out once D digits have been entered.
- ENTER_OP1:
  - digit -> shift into op1.
  - 0xA/0xB -> opcode 01/10, op2 <= 0, go ENTER_OP2.
  - "=" ignored.
- ENTER_OP2:
  - digit -> shift into op2.
  - 0xA/0xB -> replace opcode and stay; op2 unchanged.
  - "=" -> load counter with LATCH_DELAY, go WAIT.
- WAIT:
  - Counter decrements each cycle; op1/op2/opcode held stable.
  - At the edge where the counter reaches 0: result register <= alu_result, carry <= alu_c_out, go SHOW.
  - result_valid is high for exactly the following cycle.
  - Capture edge = "=" edge + LATCH_DELAY.
  - All keys except clear are ignored in WAIT.
- SHOW:
  - digit -> op1 <= {0..0, key_code}, op2 <= 0, opcode 00, go ENTER_OP1.
  - 0xA/0xB (chaining) -> op1 <= result register, op2 <= 0, opcode set, go ENTER_OP2.
  - "=" ignored.
- Clear (0xD), in any state including WAIT:
  - Same values as reset, except it is synchronous.
  - result_valid is not asserted.
- 0xE/0xF and cycles with key_strobe low: no state or register change.
- disp_value: op1 in ENTER_OP1, op2 in ENTER_OP2, op2 in WAIT, result register in SHOW.
- disp_carry: carry register in SHOW, else 0.
- No BCD validity check on alu_result; it is captured verbatim.
- Reset asserted mid-WAIT: capture is aborted, no result_valid, state ENTER_OP1.

Optional Feature:
ENTRY_DIGIT_LIMIT_EN
- Defined: once an operand holds D entered digits, further digit keys are ignored (no shift). A per-operand digit counter saturates at D and is cleared whenever its operand is cleared or reloaded.
- Undefined: shift-out behaviour as above; no digit counter.

Test Plan:
1. Reset, keys 3,7,A,1,2,C with the ALU stub returning 0x49/c=0 -> op1=0x37, op2=0x12, opcode=01; result_valid pulses 1 cycle at "=" edge+1; disp_value=0x49, disp_carry=0.
2. Keys 8,1,A,8,1,C, stub 0x62/c=1 -> SHOW with disp_value=0x62, disp_carry=1; then B -> op1=0x62, op2=0x00, opcode=10, state ENTER_OP2.
3. Keys 1,2,3 -> op1=0x23 without ENTRY_DIGIT_LIMIT_EN; op1=0x12 with it.
4. Keys 5,A,4,C, then D during WAIT with LATCH_DELAY=3 -> all outputs return to reset values, no result_valid; next key 9 -> op1=0x09.
5. nrst pulsed low mid-WAIT, asynchronous to clk -> outputs 0 immediately, opcode 00, busy 0.
6. Keys E, F, and C while in ENTER_OP1 -> no change in op1/op2/opcode/disp_value; A then B in ENTER_OP2 -> opcode ends at 10.

Source files
------------

// File: rtl/bcd_entry_sequencer.sv
// Keypad front end for the 2-digit BCD calculator: assembles operands, drives the ALU,
// captures its result after LATCH_DELAY cycles. Optional macro: ENTRY_DIGIT_LIMIT_EN.
module bcd_entry_sequencer #(
   parameter int WIDTH       = 8,
   parameter int LATCH_DELAY = 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             key_strobe,
   input  logic [3:0]       key_code,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_c_out,
   output logic [WIDTH-1:0] op1,
   output logic [WIDTH-1:0] op2,
   output logic [1:0]       opcode,
   output logic [WIDTH-1:0] disp_value,
   output logic             disp_carry,
   output logic             result_valid,
   output logic             busy
);

   localparam int D     = WIDTH / 4;
   localparam int CNT_W = $clog2(LATCH_DELAY + 1);

   localparam logic [1:0] ST_OP1  = 2'd0;
   localparam logic [1:0] ST_OP2  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_SHOW = 2'd3;

   logic [1:0]       state;
   logic [WIDTH-1:0] res_reg;
   logic             carry_reg;
   logic [CNT_W-1:0] cnt;

   logic key_dig, key_op, key_eq, key_clr;
   logic [1:0] op_sel;
   logic op1_room, op2_room;
   logic op1_shift, op2_shift;

   function automatic logic [WIDTH-1:0] shift_digit(input logic [WIDTH-1:0] opnd,
                                                   input logic [3:0] dig);
      return (opnd << 4) | WIDTH'(dig);
   endfunction

   assign key_dig = key_strobe && (key_code <= 4'd9);
   assign key_op  = key_strobe && ((key_code == 4'hA) || (key_code == 4'hB));
   assign key_eq  = key_strobe && (key_code == 4'hC);
   assign key_clr = key_strobe && (key_code == 4'hD);
   assign op_sel  = (key_code == 4'hA) ? 2'b01 : 2'b10;

   assign op1_shift = key_dig && (state == ST_OP1) && op1_room;
   assign op2_shift = key_dig && (state == ST_OP2) && op2_room;

`ifdef ENTRY_DIGIT_LIMIT_EN
   localparam int DC_W = $clog2(D + 1);

   logic [DC_W-1:0] dcnt1, dcnt2;

   function automatic logic [DC_W-1:0] sat_inc(input logic [DC_W-1:0] c);
      return (c >= DC_W'(D)) ? c : c + 1'b1;
   endfunction

   assign op1_room = (dcnt1 < DC_W'(D));
   assign op2_room = (dcnt2 < DC_W'(D));

   // A digit typed in SHOW reloads op1 with that single digit, so it already counts as one.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         dcnt1 <= '0;
         dcnt2 <= '0;
      end else if (key_clr) begin
         dcnt1 <= '0;
         dcnt2 <= '0;
      end else begin
         if (op1_shift)
            dcnt1 <= sat_inc(dcnt1);
         else if ((state == ST_SHOW) && key_dig)
            dcnt1 <= DC_W'(1);
         else if ((state == ST_SHOW) && key_op)
            dcnt1 <= '0;

         if (op2_shift)
            dcnt2 <= sat_inc(dcnt2);
         else if (((state == ST_OP1) || (state == ST_SHOW)) && key_op)
            dcnt2 <= '0;
         else if ((state == ST_SHOW) && key_dig)
            dcnt2 <= '0;
      end
   end
`else
   assign op1_room = 1'b1;
   assign op2_room = 1'b1;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= ST_OP1;
         op1          <= '0;
         op2          <= '0;
         opcode       <= 2'b00;
         res_reg      <= '0;
         carry_reg    <= 1'b0;
         cnt          <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (key_clr) begin
            state     <= ST_OP1;
            op1       <= '0;
            op2       <= '0;
            opcode    <= 2'b00;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
         end else begin
            case (state)
               ST_OP1: begin
                  if (op1_shift) begin
                     op1 <= shift_digit(op1, key_code);
                  end else if (key_op) begin
                     opcode <= op_sel;
                     op2    <= '0;
                     state  <= ST_OP2;
                  end
               end
               ST_OP2: begin
                  if (op2_shift) begin
                     op2 <= shift_digit(op2, key_code);
                  end else if (key_op) begin
                     opcode <= op_sel;
                  end else if (key_eq) begin
                     cnt   <= CNT_W'(LATCH_DELAY);
                     state <= ST_WAIT;
                  end
               end
               // Capture lands exactly LATCH_DELAY edges after the "=" edge.
               ST_WAIT: begin
                  if (cnt == CNT_W'(1)) begin
                     cnt          <= '0;
                     res_reg      <= alu_result;
                     carry_reg    <= alu_c_out;
                     result_valid <= 1'b1;
                     state        <= ST_SHOW;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               ST_SHOW: begin
                  if (key_dig) begin
                     op1    <= WIDTH'(key_code);
                     op2    <= '0;
                     opcode <= 2'b00;
                     state  <= ST_OP1;
                  end else if (key_op) begin
                     op1    <= res_reg;
                     op2    <= '0;
                     opcode <= op_sel;
                     state  <= ST_OP2;
                  end
               end
               default: state <= ST_OP1;
            endcase
         end
      end
   end

   always_comb begin
      disp_value = op1;
      disp_carry = 1'b0;
      case (state)
         ST_OP2, ST_WAIT: disp_value = op2;
         ST_SHOW: begin
            disp_value = res_reg;
            disp_carry = carry_reg;
         end
         default: ;
      endcase
   end

   assign busy = (state == ST_WAIT);

endmodule

// File: tb/tb_bcd_entry_sequencer.sv
// Scoreboard bench for bcd_entry_sequencer: key/probe snapshots and captured results are
// queued by the stimulus and checked by independent monitors.
module tb_bcd_entry_sequencer;

   localparam int W  = 8;
   localparam int LD = 3;
`ifdef ENTRY_DIGIT_LIMIT_EN
   localparam logic [7:0] T3 = 8'h12;
`else
   localparam logic [7:0] T3 = 8'h23;
`endif

   logic         tb_clk = 1'b0;
   logic         nrst;
   logic         key_strobe;
   logic [3:0]   key_code;
   logic [W-1:0] alu_result;
   logic         alu_c_out;
   logic [W-1:0] op1, op2, disp_value;
   logic [1:0]   opcode;
   logic         disp_carry, result_valid, busy;

   bcd_entry_sequencer #(.WIDTH(W), .LATCH_DELAY(LD)) dut (
      .clk(tb_clk), .nrst(nrst), .key_strobe(key_strobe), .key_code(key_code),
      .alu_result(alu_result), .alu_c_out(alu_c_out), .op1(op1), .op2(op2),
      .opcode(opcode), .disp_value(disp_value), .disp_carry(disp_carry),
      .result_valid(result_valid), .busy(busy)
   );

   always #5 tb_clk = ~tb_clk;

   typedef struct packed {
      logic [7:0] op1;
      logic [7:0] op2;
      logic [1:0] opc;
      logic [7:0] disp;
      logic       carry;
      logic       busy;
   } snap_t;

   typedef struct {
      snap_t s;
      string name;
   } exp_t;

   typedef struct {
      snap_t s;
      int    cyc;
      string name;
   } res_t;

   exp_t  snap_q[$];
   res_t  res_q[$];
   int    checks = 0;
   int    passed = 0;
   int    cyc = 0;
   logic  probe_s = 1'b0;
   logic  arm_async = 1'b0;
   exp_t  km_e, am_e;
   res_t  rm_r;

   always @(posedge tb_clk) cyc <= cyc + 1;

   function automatic snap_t S(input logic [7:0] o1, input logic [7:0] o2, input logic [1:0] oc,
                               input logic [7:0] d, input logic c, input logic b);
      return {o1, o2, oc, d, c, b};
   endfunction

   task automatic compare(input string name, input snap_t e);
      snap_t a;
      a = {op1, op2, opcode, disp_value, disp_carry, busy};
      checks++;
      if (a == e) passed++;
      else $display("FAIL %s: got op1=%h op2=%h opc=%b disp=%h carry=%b busy=%b, expected op1=%h op2=%h opc=%b disp=%h carry=%b busy=%b",
                    name, a.op1, a.op2, a.opc, a.disp, a.carry, a.busy,
                    e.op1, e.op2, e.opc, e.disp, e.carry, e.busy);
   endtask

   // Key/probe monitor: the state after the sampling edge is checked on the next falling edge.
   always begin
      @(posedge tb_clk);
      if (key_strobe || probe_s) begin
         @(negedge tb_clk);
         if (snap_q.size() == 0) begin
            checks++;
            $display("FAIL key_mon: output event with no expectation queued");
         end else begin
            km_e = snap_q.pop_front();
            compare(km_e.name, km_e.s);
         end
      end
   end

   always @(negedge tb_clk) begin
      if (nrst && result_valid) begin
         if (res_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_result_valid: got result_valid=1 at cycle %0d, expected 0", cyc);
         end else begin
            rm_r = res_q.pop_front();
            compare(rm_r.name, rm_r.s);
            checks++;
            if (cyc == rm_r.cyc) passed++;
            else $display("FAIL %s_latency: got cycle %0d, expected cycle %0d", rm_r.name, cyc, rm_r.cyc);
         end
      end
   end

   always @(negedge nrst) begin
      if (arm_async) begin
         #1;
         if (snap_q.size() == 0) begin
            checks++;
            $display("FAIL async_mon: reset event with no expectation queued");
         end else begin
            am_e = snap_q.pop_front();
            compare(am_e.name, am_e.s);
         end
      end
   end

   task automatic press(input logic [3:0] k, input string name, input snap_t e,
                        input bit with_res = 1'b0, input snap_t r = '0);
      exp_t x;
      res_t y;
      @(negedge tb_clk);
      x.s = e;
      x.name = name;
      snap_q.push_back(x);
      if (with_res) begin
         y.s = r;
         y.cyc = cyc + 1 + LD;
         y.name = {name, "_result"};
         res_q.push_back(y);
      end
      key_code   = k;
      key_strobe = 1'b1;
      @(negedge tb_clk);
      key_strobe = 1'b0;
   endtask

   task automatic probe(input string name, input snap_t e);
      exp_t x;
      @(negedge tb_clk);
      x.s = e;
      x.name = name;
      snap_q.push_back(x);
      probe_s = 1'b1;
      @(negedge tb_clk);
      probe_s = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge tb_clk);
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (res_q.size() == 0 && snap_q.size() == 0) passed++;
      else $display("FAIL %s_drained: got %0d results and %0d snapshots outstanding, expected 0",
                    name, res_q.size(), snap_q.size());
      res_q.delete();
      snap_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t x;
      nrst = 1'b0;
      key_strobe = 1'b0;
      key_code = 4'h0;
      alu_result = '0;
      alu_c_out = 1'b0;
      idle(2);
      probe("reset", S(8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0));
      @(negedge tb_clk);
      nrst = 1'b1;

      // Basic add, with a digit ignored while waiting
      alu_result = 8'h49;
      alu_c_out = 1'b0;
      press(4'h3, "t1_k3", S(8'h03, 8'h00, 2'b00, 8'h03, 1'b0, 1'b0));
      press(4'h7, "t1_k7", S(8'h37, 8'h00, 2'b00, 8'h37, 1'b0, 1'b0));
      press(4'hA, "t1_kA", S(8'h37, 8'h00, 2'b01, 8'h00, 1'b0, 1'b0));
      press(4'h1, "t1_k1", S(8'h37, 8'h01, 2'b01, 8'h01, 1'b0, 1'b0));
      press(4'h2, "t1_k2", S(8'h37, 8'h12, 2'b01, 8'h12, 1'b0, 1'b0));
      press(4'hC, "t1_kC", S(8'h37, 8'h12, 2'b01, 8'h12, 1'b0, 1'b1),
            1'b1, S(8'h37, 8'h12, 2'b01, 8'h49, 1'b0, 1'b0));
      press(4'h5, "t1_wait_k5", S(8'h37, 8'h12, 2'b01, 8'h12, 1'b0, 1'b1));
      idle(LD + 2);
      check_drained("t1");

      // Carry capture and chaining from SHOW
      press(4'h8, "t2_k8", S(8'h08, 8'h00, 2'b00, 8'h08, 1'b0, 1'b0));
      press(4'h1, "t2_k1", S(8'h81, 8'h00, 2'b00, 8'h81, 1'b0, 1'b0));
      press(4'hA, "t2_kA", S(8'h81, 8'h00, 2'b01, 8'h00, 1'b0, 1'b0));
      press(4'h8, "t2_k8b", S(8'h81, 8'h08, 2'b01, 8'h08, 1'b0, 1'b0));
      press(4'h1, "t2_k1b", S(8'h81, 8'h81, 2'b01, 8'h81, 1'b0, 1'b0));
      alu_result = 8'h62;
      alu_c_out = 1'b1;
      press(4'hC, "t2_kC", S(8'h81, 8'h81, 2'b01, 8'h81, 1'b0, 1'b1),
            1'b1, S(8'h81, 8'h81, 2'b01, 8'h62, 1'b1, 1'b0));
      idle(LD + 2);
      check_drained("t2");
      press(4'hB, "t2_chainB", S(8'h62, 8'h00, 2'b10, 8'h00, 1'b0, 1'b0));
      press(4'hD, "t2_clear", S(8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0));

      // Digit overflow, ignored keys, opcode replacement
      press(4'h1, "t3_k1", S(8'h01, 8'h00, 2'b00, 8'h01, 1'b0, 1'b0));
      press(4'h2, "t3_k2", S(8'h12, 8'h00, 2'b00, 8'h12, 1'b0, 1'b0));
      press(4'h3, "t3_k3", S(T3, 8'h00, 2'b00, T3, 1'b0, 1'b0));
      press(4'hE, "t6_kE", S(T3, 8'h00, 2'b00, T3, 1'b0, 1'b0));
      press(4'hF, "t6_kF", S(T3, 8'h00, 2'b00, T3, 1'b0, 1'b0));
      press(4'hC, "t6_eq_in_op1", S(T3, 8'h00, 2'b00, T3, 1'b0, 1'b0));
      press(4'hA, "t6_kA", S(T3, 8'h00, 2'b01, 8'h00, 1'b0, 1'b0));
      press(4'hB, "t6_kB", S(T3, 8'h00, 2'b10, 8'h00, 1'b0, 1'b0));

      // Clear during WAIT aborts the capture
      press(4'hD, "t4_pre_clear", S(8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0));
      press(4'h5, "t4_k5", S(8'h05, 8'h00, 2'b00, 8'h05, 1'b0, 1'b0));
      press(4'hA, "t4_kA", S(8'h05, 8'h00, 2'b01, 8'h00, 1'b0, 1'b0));
      press(4'h4, "t4_k4", S(8'h05, 8'h04, 2'b01, 8'h04, 1'b0, 1'b0));
      press(4'hC, "t4_kC", S(8'h05, 8'h04, 2'b01, 8'h04, 1'b0, 1'b1));
      press(4'hD, "t4_wait_clear", S(8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0));
      idle(LD + 3);
      press(4'h9, "t4_k9", S(8'h09, 8'h00, 2'b00, 8'h09, 1'b0, 1'b0));

      // Asynchronous reset in the middle of WAIT
      press(4'hD, "t5_pre_clear", S(8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0));
      press(4'h5, "t5_k5", S(8'h05, 8'h00, 2'b00, 8'h05, 1'b0, 1'b0));
      press(4'hA, "t5_kA", S(8'h05, 8'h00, 2'b01, 8'h00, 1'b0, 1'b0));
      press(4'h4, "t5_k4", S(8'h05, 8'h04, 2'b01, 8'h04, 1'b0, 1'b0));
      press(4'hC, "t5_kC", S(8'h05, 8'h04, 2'b01, 8'h04, 1'b0, 1'b1));
      @(posedge tb_clk);
      #3;
      x.s = S(8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
      x.name = "t5_async_reset";
      snap_q.push_back(x);
      arm_async = 1'b1;
      nrst = 1'b0;
      #3;
      arm_async = 1'b0;
      idle(2);
      nrst = 1'b1;
      idle(LD + 3);
      probe("t5_after_reset", S(8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0));

      idle(2);
      check_drained("final");
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
